// File: rtl/dac_spi_tx.sv
// dac_spi_tx: saturates a 16-bit sample to a 12-bit DAC code and sends it
// MSB-first as a 16-bit {CMD, code} frame to an SPI DAC (sclk idle high,
// data launched on rising sclk, sampled by the DAC on falling sclk).
// Optional build macro DAC_SPI_TX_HOLD_EN adds a one-entry pending register
// so a request arriving while busy is sent right after the current frame.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'b0011,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample_in,
  input  logic        sample_vld,
  output logic        busy,
  output logic        done,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic                 busy_d, done_d, sclk_d, sync_n_d, din_d;
  logic [FRAME_W-1:0]   frame_c;
  logic                 start_c;
  logic [FRAME_W-1:0]   start_frame_c;
`ifdef DAC_SPI_TX_HOLD_EN
  logic                 pend_q, pend_d;
  logic [FRAME_W-1:0]   pend_frame_q, pend_frame_d;
`endif

  // Saturate the sample to 12 bits and prepend the command nibble
  always_comb begin
    frame_c = {CMD, (sample_in[15:12] == 4'd0) ? sample_in[11:0] : 12'hFFF};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    busy_d        = busy;
    done_d        = 1'b0;
    sclk_d        = dac_sclk;
    sync_n_d      = dac_sync_n;
    din_d         = dac_din;
    start_c       = 1'b0;
    start_frame_c = frame_c;
`ifdef DAC_SPI_TX_HOLD_EN
    pend_d        = pend_q;
    pend_frame_d  = pend_frame_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef DAC_SPI_TX_HOLD_EN
        // A fresh request is newer than anything left pending
        if (sample_vld || pend_q) begin
          start_c       = 1'b1;
          start_frame_c = sample_vld ? frame_c : pend_frame_q;
          pend_d        = 1'b0;
        end
`else
        if (sample_vld) begin
          start_c = 1'b1;
        end
`endif
      end

      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (dac_sclk) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == '0) begin
            state_d   = GAP;
            sclk_d    = 1'b1;
            sync_n_d  = 1'b1;
            din_d     = 1'b0;
            gap_cnt_d = '0;
            done_d    = (GAP_CYC == 1);
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            sclk_d    = 1'b1;
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            din_d     = shift_q[FRAME_W-2];
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
`ifdef DAC_SPI_TX_HOLD_EN
        if (sample_vld) begin
          pend_d       = 1'b1;
          pend_frame_d = frame_c;
        end
`endif
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
`ifdef DAC_SPI_TX_HOLD_EN
          // Chain straight into the pending frame; a request on this very
          // edge becomes the next pending entry
          if (pend_q) begin
            start_c       = 1'b1;
            start_frame_c = pend_frame_q;
            pend_d        = sample_vld;
          end else if (sample_vld) begin
            pend_d = 1'b1;
          end
          if (sample_vld) begin
            pend_frame_d = frame_c;
          end
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          done_d    = (GAP_W'(gap_cnt_q + 1'b1) == GAP_LAST);
`ifdef DAC_SPI_TX_HOLD_EN
          if (sample_vld) begin
            pend_d       = 1'b1;
            pend_frame_d = frame_c;
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Frame start: load shifter, present MSB with sclk high and sync low
    if (start_c) begin
      state_d   = SHIFT;
      shift_d   = start_frame_c;
      bit_cnt_d = BIT_W'(FRAME_W - 1);
      div_cnt_d = '0;
      busy_d    = 1'b1;
      sclk_d    = 1'b1;
      sync_n_d  = 1'b0;
      din_d     = start_frame_c[FRAME_W-1];
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dac_sclk     <= 1'b1;
      dac_sync_n   <= 1'b1;
      dac_din      <= 1'b0;
`ifdef DAC_SPI_TX_HOLD_EN
      pend_q       <= 1'b0;
      pend_frame_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      busy         <= busy_d;
      done         <= done_d;
      dac_sclk     <= sclk_d;
      dac_sync_n   <= sync_n_d;
      dac_din      <= din_d;
`ifdef DAC_SPI_TX_HOLD_EN
      pend_q       <= pend_d;
      pend_frame_q <= pend_frame_d;
`endif
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Testbench for dac_spi_tx (CLK_DIV=2, GAP_CYC=8). A timeline model predicts
// every output pin per cycle from the accept times of requests; frames are
// also decoded from the SPI pins on falling sclk and compared.
module tb_dac_spi_tx;

  localparam int unsigned C  = 2;
  localparam int unsigned G  = 8;
  localparam int          SH = 32 * C;
  localparam int          T  = 32 * C + G;
`ifdef DAC_SPI_TX_HOLD_EN
  localparam int          SPACING = T;
`else
  localparam int          SPACING = T + 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        sample_vld = 1'b0;
  logic        busy, done, dac_sclk, dac_sync_n, dac_din;

  dac_spi_tx #(.CLK_DIV(C), .CMD(4'b0011), .GAP_CYC(G)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .busy       (busy),
    .done       (done),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  // timeline model
  bit          have_acc = 1'b0;
  int          acc_n = 0;
  logic [15:0] acc_frame = 16'h0;
  bit          pend = 1'b0;
  logic [15:0] pend_frame = 16'h0;
  // pin decoder
  int          nbits = 0;
  logic [15:0] dsh = 16'h0;
  logic        prev_sclk = 1'b1;
  logic [15:0] flog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] s);
    return {4'h3, (s > 16'h0FFF) ? 12'hFFF : s[11:0]};
  endfunction

  task automatic accept(input logic [15:0] fr);
    have_acc  = 1'b1;
    acc_n     = cyc;
    acc_frame = fr;
  endtask

  // Decide from request timing whether this edge starts a frame
  task automatic model_step();
    logic [15:0] f;
    bit          busy_edge;
    f = sat(sample_in);
    if (!reset_n) begin
      have_acc = 1'b0;
      pend     = 1'b0;
      return;
    end
    busy_edge = have_acc && (cyc - acc_n >= 1) && (cyc - acc_n <= T);
`ifdef DAC_SPI_TX_HOLD_EN
    if (busy_edge) begin
      if ((cyc - acc_n == T) && pend) begin
        accept(pend_frame);
        pend = sample_vld;
        if (sample_vld) pend_frame = f;
      end else if (sample_vld) begin
        pend = 1'b1;
        pend_frame = f;
      end
    end else if (sample_vld) begin
      accept(f);
      pend = 1'b0;
    end else if (pend) begin
      accept(pend_frame);
      pend = 1'b0;
    end
`else
    if (!busy_edge && sample_vld) accept(f);
`endif
  endtask

  // Expected {busy, done, sclk, sync_n, din} for the current cycle
  function automatic logic [4:0] exp_pins();
    int k;
    if (!have_acc) return 5'b00110;
    k = cyc - acc_n;
    if (k < SH) return {1'b1, 1'b0, ((k / C) % 2 == 0), 1'b0, acc_frame[15 - k / (2 * C)]};
    if (k < T) return {1'b1, (k == T - 1), 1'b1, 1'b1, 1'b0};
    return 5'b00110;
  endfunction

  task automatic decode();
    if (!reset_n) begin
      nbits = 0;
    end else if (!dac_sync_n) begin
      if (prev_sclk && !dac_sclk) begin
        dsh = {dsh[14:0], dac_din};
        nbits++;
      end
    end else if (nbits != 0) begin
      check("frame_bits", nbits, 16);
      check("frame", {16'h0, dsh}, {16'h0, acc_frame});
      flog.push_back(dsh);
      nbits = 0;
    end
    prev_sclk = dac_sclk;
  endtask

  // One clock: model sees the edge, then pins are checked mid-low-phase
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check("pins", {27'h0, busy, done, dac_sclk, dac_sync_n, dac_din}, {27'h0, exp_pins()});
    decode();
  endtask

  task automatic pulse(input logic [15:0] s);
    sample_in  = s;
    sample_vld = 1'b1;
    tick();
    sample_vld = 1'b0;
    sample_in  = 16'($urandom);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((busy || (have_acc && cyc - acc_n < T)) && budget < 400) begin
      tick();
      budget++;
    end
    check("idle_timeout", {31'h0, busy}, 32'h0);
    tick();
  endtask

  initial begin
    int nb, ns, nd, base;
    int starts[$];
    logic ps;

    // reset
    ticks(3);
    check("reset", {27'h0, busy, done, dac_sclk, dac_sync_n, dac_din}, {27'h0, 5'b00110});
    reset_n = 1'b1;
    ticks(2);

    // basic frame and its timing
    base = flog.size();
    nb = 0; ns = 0; nd = 0;
    sample_in = 16'h0123;
    sample_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      sample_vld = 1'b0;
      nb += int'(busy);
      ns += int'(!dac_sync_n);
      nd += int'(done);
    end
    check("busy_len", nb, 72);
    check("sync_len", ns, 64);
    check("done_cnt", nd, 1);
    check("n_0123", flog.size() - base, 1);
    if (flog.size() > base) check("f_0123", {16'h0, flog[base]}, 32'h3123);

    // saturation corners
    pulse(16'h07F8); wait_idle();
    check("f_07F8", {16'h0, flog[$]}, 32'h37F8);
    pulse(16'h1000); wait_idle();
    check("f_1000", {16'h0, flog[$]}, 32'h3FFF);
    pulse(16'hFFFF); wait_idle();
    check("f_FFFF", {16'h0, flog[$]}, 32'h3FFF);

    // request during a frame
    base = flog.size();
    pulse(16'h0AAA);
    ticks(19);
    pulse(16'h0555);
    ticks(200);
`ifdef DAC_SPI_TX_HOLD_EN
    check("n_hold", flog.size() - base, 2);
    if (flog.size() > base + 1) check("f_hold2", {16'h0, flog[base + 1]}, 32'h3555);
`else
    check("n_drop", flog.size() - base, 1);
`endif
    if (flog.size() > base) check("f_0AAA", {16'h0, flog[base]}, 32'h3AAA);

    // three requests during one frame
    base = flog.size();
    pulse(16'h0009);
    ticks(9);  pulse(16'h0001);
    ticks(9);  pulse(16'h0002);
    ticks(9);  pulse(16'h0003);
    ticks(200);
`ifdef DAC_SPI_TX_HOLD_EN
    check("n_three", flog.size() - base, 2);
    if (flog.size() > base + 1) check("f_three", {16'h0, flog[base + 1]}, 32'h3003);
`else
    check("n_three", flog.size() - base, 1);
`endif

    // asynchronous reset at bit 7
    base = flog.size();
    pulse(16'h0ABC);
    ticks(7 * 2 * C - 1);
    @(posedge clk);
    cyc++;
    model_step();
    #2 reset_n = 1'b0;
    have_acc = 1'b0;
    pend = 1'b0;
    #1 check("rst_async", {27'h0, busy, done, dac_sclk, dac_sync_n, dac_din}, {27'h0, 5'b00110});
    @(negedge clk);
    check("pins", {27'h0, busy, done, dac_sclk, dac_sync_n, dac_din}, {27'h0, exp_pins()});
    decode();
    ticks(3);
    reset_n = 1'b1;
    check("n_abort", flog.size() - base, 0);
    tick();
    pulse(16'h0456); wait_idle();
    check("n_after_rst", flog.size() - base, 1);
    check("f_after_rst", {16'h0, flog[$]}, 32'h3456);

    // sample_vld held high
    ps = dac_sync_n;
    sample_vld = 1'b1;
    for (int i = 0; i < 400; i++) begin
      sample_in = 16'($urandom_range(0, 16'h1FFF));
      tick();
      if (ps && !dac_sync_n) starts.push_back(cyc);
      ps = dac_sync_n;
    end
    sample_vld = 1'b0;
    wait_idle();
    check("held_frames", {31'h0, starts.size() >= 5}, 32'h1);
    for (int i = 1; i < starts.size(); i++) check("spacing", starts[i] - starts[i - 1], SPACING);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sample_vld = ($urandom_range(0, 19) == 0);
      sample_in  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
      tick();
    end
    sample_vld = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
